lamp_strobe_ctrl: RTL and testbench
===================================

LAMP_STROBE_CTRL -- requirements
Module: lamp_strobe_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 48000, meaning sys_clk cycles per 1 ms tick (must be ≥2).
REQ-002 SHALL have port sys_clk  input  1  system clock; the block uses this single clock domain only.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous to sys_clk, active-high.
REQ-004 SHALL have port acq_start  input  1  one-cycle request to start an integration.
REQ-005 SHALL have port int_clock  input  16  integration time in ms.
REQ-006 SHALL have port ss_high_delay  input  16  ms from integration start to single_strobe rising.
REQ-007 SHALL have port ss_low_delay  input  16  ms from integration start to single_strobe falling.
REQ-008 SHALL have port count_base  input  16  sys_clk cycles per continuous-strobe base tick.
REQ-009 SHALL have port strb_count  input  16  base ticks per cont_strobe half-period.
REQ-010 SHALL have port lamp_enable  input  16  bit0 enables single strobe; bit1 enables continuous strobe; other bits ignored.
REQ-011 SHALL have port integ_active  output  1  high while integrating.
REQ-012 SHALL have port integ_done  output  1  one-cycle pulse at integration end.
REQ-013 SHALL have port single_strobe  output  1  single lamp strobe.
REQ-014 SHALL have port cont_strobe  output  1  continuous lamp strobe.
REQ-015 SHALL have port ms_elapsed  output  16  ms elapsed in the current integration.

Function
REQ-016 SHALL implement FSM states IDLE, INTEG, DONE; IDLE->INTEG on acq_start; INTEG->DONE at end of integration; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL accept acq_start only in IDLE and ignore it in INTEG and DONE, with no queuing.
REQ-018 SHALL, on accepting acq_start, latch int_clock, ss_high_delay and ss_low_delay into shadow registers; later changes to those inputs do not affect the running integration.
REQ-019 SHALL treat a latched int_clock of 0 as 1.
REQ-020 SHALL run the ms prescaler 0..CLK_PER_MS-1 only in INTEG, clearing it to 0 on acq_start acceptance; ms_tick asserts when the prescaler equals CLK_PER_MS-1.
REQ-021 SHALL drive integ_active high in exactly cycles N+1 .. N+len*CLK_PER_MS, where N is the acq_start acceptance cycle and len is the latched int_clock.
REQ-022 SHALL clear ms_elapsed to 0 on acceptance and increment it on each ms_tick in INTEG; when ms_tick coincides with ms_elapsed == len-1, go to DONE.
REQ-023 SHALL hold ms_elapsed at its final value in DONE and IDLE.
REQ-024 SHALL assert integ_done only in DONE, for one cycle, with integ_active low.
REQ-025 SHALL set single_strobe = INTEG && lamp_enable[0] && ms_elapsed >= ss_high && ms_elapsed < ss_low, registered to one cycle after the state/ms_elapsed update.
REQ-026 SHALL apply lamp_enable[0] live, not latched; clearing it mid-integration drops single_strobe on the next cycle.
REQ-027 SHALL never assert single_strobe when ss_low <= ss_high.
REQ-028 SHALL run the continuous strobe free-running, independent of the FSM.
REQ-029 SHALL use a base prescaler counting 0..count_base-1 that emits base_tick; cont_strobe toggles every strb_count base_ticks.
REQ-030 SHALL treat a count_base or strb_count of 0 as 1.
REQ-031 SHALL compare counters with >= against the live count_base and strb_count, so a reduction mid-count wraps to 0 on the next cycle with no lockup.
REQ-032 SHALL, when lamp_enable[1] = 0, hold cont_strobe low and both continuous counters at 0; re-enabling starts a fresh low half-period.

Reset
REQ-033 SHALL, while sys_rst = 1, force state IDLE, all counters and shadow registers 0, and every output 0.
REQ-034 SHALL abort an integration on reset mid-operation with no integ_done pulse.
REQ-035 SHALL make sys_rst take priority over acq_start in the same cycle.

Configuration
REQ-036 SHALL, with macro LAMP_STROBE_CONT_EN defined, include the continuous-strobe logic of REQ-028..REQ-032.
REQ-037 SHALL, without LAMP_STROBE_CONT_EN, tie cont_strobe to constant 0, leave count_base, strb_count and lamp_enable[1] unused, and generate no continuous-strobe counters; all other behaviour is identical.

Verification (CLK_PER_MS=4 for all scenarios)
REQ-038 SHALL check: int_clock=3, acq_start at cycle 10 -> integ_active high cycles 11..22; integ_done at cycle 23; ms_elapsed ends at 3.
REQ-039 SHALL check: lamp_enable=1, ss_high=1, ss_low=2, int_clock=3 -> single_strobe high for exactly 4 cycles during ms_elapsed=1; ss_low=1, ss_high=2 -> never high.
REQ-040 SHALL check: int_clock=0 -> integ_active high 4 cycles; a second acq_start during INTEG and on the DONE cycle -> ignored; an acq_start the cycle after DONE -> accepted.
REQ-041 SHALL check: int_clock changed from 3 to 10 mid-integration -> the integration still lasts 12 cycles.
REQ-042 SHALL check: with LAMP_STROBE_CONT_EN, lamp_enable=2, count_base=2, strb_count=3 -> cont_strobe period 12 cycles at 50% duty; lamp_enable=0 -> low within 1 cycle; without the macro -> constantly 0.
REQ-043 SHALL check: sys_rst asserted at ms_elapsed=1 of a 3 ms integration -> all outputs 0 the next cycle, no integ_done, and a new acq_start after reset runs a full integration.

Source files
------------

// File: rtl/lamp_strobe_ctrl.sv
// Lamp strobe controller: ms-based integration FSM with a single strobe window,
// plus an optional free-running continuous strobe enabled by macro LAMP_STROBE_CONT_EN.
module lamp_strobe_ctrl #(
  parameter int CLK_PER_MS = 48000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        acq_start,
  input  logic [15:0] int_clock,
  input  logic [15:0] ss_high_delay,
  input  logic [15:0] ss_low_delay,
  input  logic [15:0] count_base,
  input  logic [15:0] strb_count,
  input  logic [15:0] lamp_enable,
  output logic        integ_active,
  output logic        integ_done,
  output logic        single_strobe,
  output logic        cont_strobe,
  output logic [15:0] ms_elapsed
);

  localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] len_q, len_d;
  logic [15:0] ss_high_q, ss_high_d;
  logic [15:0] ss_low_q, ss_low_d;
  logic        integ_active_q, integ_active_d;
  logic        integ_done_q, integ_done_d;
  logic        single_strobe_q, single_strobe_d;
  logic        ms_tick;

  assign ms_tick = (state_q == INTEG) && (pre_q == PRE_MAX);

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    len_d     = len_q;
    ss_high_d = ss_high_q;
    ss_low_d  = ss_low_q;
    case (state_q)
      IDLE: begin
        if (acq_start) begin
          state_d   = INTEG;
          pre_d     = '0;
          ms_d      = 16'd0;
          // A zero-length request still runs a 1 ms integration.
          len_d     = (int_clock == 16'd0) ? 16'd1 : int_clock;
          ss_high_d = ss_high_delay;
          ss_low_d  = ss_low_delay;
        end
      end
      INTEG: begin
        pre_d = ms_tick ? '0 : pre_q + PW'(1);
        if (ms_tick) begin
          ms_d = ms_q + 16'd1;
          if (ms_q == len_q - 16'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    integ_active_d  = (state_d == INTEG);
    integ_done_d    = (state_d == DONE);
    // Window evaluated on the current state, so the strobe lags ms_elapsed by one cycle.
    single_strobe_d = (state_q == INTEG) && lamp_enable[0] &&
                      (ms_q >= ss_high_q) && (ms_q < ss_low_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= IDLE;
      pre_q           <= '0;
      ms_q            <= 16'd0;
      len_q           <= 16'd0;
      ss_high_q       <= 16'd0;
      ss_low_q        <= 16'd0;
      integ_active_q  <= 1'b0;
      integ_done_q    <= 1'b0;
      single_strobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pre_q           <= pre_d;
      ms_q            <= ms_d;
      len_q           <= len_d;
      ss_high_q       <= ss_high_d;
      ss_low_q        <= ss_low_d;
      integ_active_q  <= integ_active_d;
      integ_done_q    <= integ_done_d;
      single_strobe_q <= single_strobe_d;
    end
  end

  assign integ_active  = integ_active_q;
  assign integ_done    = integ_done_q;
  assign single_strobe = single_strobe_q;
  assign ms_elapsed    = ms_q;

`ifdef LAMP_STROBE_CONT_EN
  logic [15:0] base_q, base_d;
  logic [15:0] strb_q, strb_d;
  logic        cont_q, cont_d;
  logic [15:0] cb_eff;
  logic [15:0] sc_eff;
  logic        base_tick;
  logic        unused_lamp;

  assign unused_lamp = ^lamp_enable[15:2];
  assign cb_eff      = (count_base == 16'd0) ? 16'd1 : count_base;
  assign sc_eff      = (strb_count == 16'd0) ? 16'd1 : strb_count;

  // >= against the live limits lets a mid-count reduction wrap instead of overrunning.
  always_comb begin
    base_d    = base_q;
    strb_d    = strb_q;
    cont_d    = cont_q;
    base_tick = 1'b0;
    if (!lamp_enable[1]) begin
      base_d = 16'd0;
      strb_d = 16'd0;
      cont_d = 1'b0;
    end else begin
      base_tick = (base_q >= cb_eff - 16'd1);
      base_d    = base_tick ? 16'd0 : base_q + 16'd1;
      if (base_tick) begin
        if (strb_q >= sc_eff - 16'd1) begin
          strb_d = 16'd0;
          cont_d = ~cont_q;
        end else begin
          strb_d = strb_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      base_q <= 16'd0;
      strb_q <= 16'd0;
      cont_q <= 1'b0;
    end else begin
      base_q <= base_d;
      strb_q <= strb_d;
      cont_q <= cont_d;
    end
  end

  assign cont_strobe = cont_q;
`else
  logic unused_cont;

  assign unused_cont = ^{count_base, strb_count, lamp_enable[15:1]};
  assign cont_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_strobe_ctrl.sv
// Directed self-checking bench for lamp_strobe_ctrl with CLK_PER_MS = 4.
module tb_lamp_strobe_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        acq_start;
  logic [15:0] int_clock;
  logic [15:0] ss_high_delay;
  logic [15:0] ss_low_delay;
  logic [15:0] count_base;
  logic [15:0] strb_count;
  logic [15:0] lamp_enable;
  logic        integ_active;
  logic        integ_done;
  logic        single_strobe;
  logic        cont_strobe;
  logic [15:0] ms_elapsed;

  int checks = 0;
  int errors = 0;

  lamp_strobe_ctrl #(.CLK_PER_MS(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .acq_start    (acq_start),
    .int_clock    (int_clock),
    .ss_high_delay(ss_high_delay),
    .ss_low_delay (ss_low_delay),
    .count_base   (count_base),
    .strb_count   (strb_count),
    .lamp_enable  (lamp_enable),
    .integ_active (integ_active),
    .integ_done   (integ_done),
    .single_strobe(single_strobe),
    .cont_strobe  (cont_strobe),
    .ms_elapsed   (ms_elapsed)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    acq_start = 1'b1;
    tick();
    tick();
    checks++;
    if ({integ_active, integ_done, single_strobe, cont_strobe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000",
               {integ_active, integ_done, single_strobe, cont_strobe});
    end
    checks++;
    if (ms_elapsed !== 16'd0) begin
      errors++;
      $display("FAIL reset_ms got=%0d want=0", ms_elapsed);
    end
    acq_start = 1'b0;
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_integ_timing();
    int_clock = 16'd3;
    acq_start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      acq_start = 1'b0;
      checks++;
      if (integ_active !== (k <= 12)) begin
        errors++;
        $display("FAIL timing_active k=%0d got=%b want=%b", k, integ_active, (k <= 12));
      end
      checks++;
      if (integ_done !== (k == 13)) begin
        errors++;
        $display("FAIL timing_done k=%0d got=%b want=%b", k, integ_done, (k == 13));
      end
    end
    checks++;
    if (ms_elapsed !== 16'd3) begin
      errors++;
      $display("FAIL timing_ms_final got=%0d want=3", ms_elapsed);
    end
  endtask

  task automatic test_single_strobe();
    int hi_cnt;
    int_clock = 16'd3;
    lamp_enable = 16'd1;
    ss_high_delay = 16'd1;
    ss_low_delay = 16'd2;
    hi_cnt = 0;
    acq_start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      acq_start = 1'b0;
      if (single_strobe === 1'b1) hi_cnt++;
      checks++;
      if (single_strobe !== (k >= 6 && k <= 9)) begin
        errors++;
        $display("FAIL strobe_window k=%0d got=%b want=%b", k, single_strobe, (k >= 6 && k <= 9));
      end
    end
    checks++;
    if (hi_cnt != 4) begin
      errors++;
      $display("FAIL strobe_width got=%0d want=4", hi_cnt);
    end
    // Inverted window must never fire.
    ss_high_delay = 16'd2;
    ss_low_delay = 16'd1;
    hi_cnt = 0;
    acq_start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      acq_start = 1'b0;
      if (single_strobe === 1'b1) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 0) begin
      errors++;
      $display("FAIL strobe_inverted got=%0d want=0", hi_cnt);
    end
    // Live enable: window covers ms 0..2, enable cleared during cycle 4.
    ss_high_delay = 16'd0;
    ss_low_delay = 16'd3;
    acq_start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      acq_start = 1'b0;
      if (k == 3) begin
        checks++;
        if (single_strobe !== 1'b1) begin
          errors++;
          $display("FAIL strobe_live_on got=%b want=1", single_strobe);
        end
      end
      if (k == 5) begin
        checks++;
        if (single_strobe !== 1'b0) begin
          errors++;
          $display("FAIL strobe_live_off got=%b want=0", single_strobe);
        end
      end
      if (k == 4) lamp_enable = 16'd0;
    end
  endtask

  task automatic test_back_to_back();
    logic exp_act, exp_done;
    int_clock = 16'd0;
    acq_start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_act  = (k <= 4) || (k >= 7 && k <= 10);
      exp_done = (k == 5) || (k == 11);
      checks++;
      if (integ_active !== exp_act) begin
        errors++;
        $display("FAIL b2b_active k=%0d got=%b want=%b", k, integ_active, exp_act);
      end
      checks++;
      if (integ_done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done k=%0d got=%b want=%b", k, integ_done, exp_done);
      end
      acq_start = (k == 2) || (k == 5) || (k == 6);
    end
    acq_start = 1'b0;
  endtask

  task automatic test_shadow();
    int act_cnt;
    int done_k;
    int_clock = 16'd3;
    act_cnt = 0;
    done_k = 0;
    acq_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      acq_start = 1'b0;
      if (integ_active === 1'b1) act_cnt++;
      if (integ_done === 1'b1 && done_k == 0) done_k = k;
      if (k == 3) int_clock = 16'd10;
    end
    checks++;
    if (act_cnt != 12) begin
      errors++;
      $display("FAIL shadow_len got=%0d want=12", act_cnt);
    end
    checks++;
    if (done_k != 13) begin
      errors++;
      $display("FAIL shadow_done_cycle got=%0d want=13", done_k);
    end
    int_clock = 16'd3;
  endtask

  task automatic test_reset_abort();
    int guard;
    int done_seen;
    int act_cnt;
    int_clock = 16'd3;
    lamp_enable = 16'd1;
    ss_high_delay = 16'd0;
    ss_low_delay = 16'd3;
    acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    guard = 0;
    while (ms_elapsed !== 16'd1 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (ms_elapsed !== 16'd1) begin
      errors++;
      $display("FAIL abort_reach_ms1 got=%0d want=1", ms_elapsed);
    end
    sys_rst = 1'b1;
    tick();
    checks++;
    if ({integ_active, integ_done, single_strobe, cont_strobe} !== 4'b0000 ||
        ms_elapsed !== 16'd0) begin
      errors++;
      $display("FAIL abort_outputs got=%b ms=%0d want=0000 ms=0",
               {integ_active, integ_done, single_strobe, cont_strobe}, ms_elapsed);
    end
    // Reset wins over a simultaneous start.
    acq_start = 1'b1;
    tick();
    sys_rst = 1'b0;
    acq_start = 1'b0;
    done_seen = 0;
    act_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (integ_done === 1'b1) done_seen++;
      if (integ_active === 1'b1) act_cnt++;
    end
    checks++;
    if (done_seen != 0 || act_cnt != 0) begin
      errors++;
      $display("FAIL abort_quiet done=%0d active=%0d want=0 0", done_seen, act_cnt);
    end
    acq_start = 1'b1;
    act_cnt = 0;
    done_seen = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      acq_start = 1'b0;
      if (integ_active === 1'b1) act_cnt++;
      if (integ_done === 1'b1) done_seen++;
    end
    checks++;
    if (act_cnt != 12 || done_seen != 1 || ms_elapsed !== 16'd3) begin
      errors++;
      $display("FAIL abort_restart active=%0d done=%0d ms=%0d want=12 1 3",
               act_cnt, done_seen, ms_elapsed);
    end
    lamp_enable = 16'd0;
  endtask

  task automatic test_cont();
`ifdef LAMP_STROBE_CONT_EN
    int first_rise;
    int hi_len;
    int lo_len;
    int guard;
    count_base = 16'd2;
    strb_count = 16'd3;
    lamp_enable = 16'd2;
    first_rise = 0;
    for (int k = 1; k <= 20 && first_rise == 0; k++) begin
      tick();
      if (cont_strobe === 1'b1) first_rise = k;
    end
    checks++;
    if (first_rise != 6) begin
      errors++;
      $display("FAIL cont_first_rise got=%0d want=6", first_rise);
    end
    hi_len = 1;
    guard = 0;
    while (cont_strobe === 1'b1 && guard < 40) begin
      tick();
      guard++;
      if (cont_strobe === 1'b1) hi_len++;
    end
    lo_len = 1;
    guard = 0;
    while (cont_strobe === 1'b0 && guard < 40) begin
      tick();
      guard++;
      if (cont_strobe === 1'b0) lo_len++;
    end
    checks++;
    if (hi_len != 6 || lo_len != 6) begin
      errors++;
      $display("FAIL cont_period high=%0d low=%0d want=6 6", hi_len, lo_len);
    end
    lamp_enable = 16'd0;
    tick();
    checks++;
    if (cont_strobe !== 1'b0) begin
      errors++;
      $display("FAIL cont_disable got=%b want=0", cont_strobe);
    end
`else
    int hi_cnt;
    count_base = 16'd2;
    strb_count = 16'd3;
    lamp_enable = 16'd3;
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (cont_strobe !== 1'b0) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 0) begin
      errors++;
      $display("FAIL cont_tied_low got=%0d want=0", hi_cnt);
    end
    lamp_enable = 16'd0;
`endif
  endtask

  initial begin
    sys_rst = 1'b1;
    acq_start = 1'b0;
    int_clock = 16'd0;
    ss_high_delay = 16'd0;
    ss_low_delay = 16'd0;
    count_base = 16'd0;
    strb_count = 16'd0;
    lamp_enable = 16'd0;
    test_reset();
    test_integ_timing();
    test_single_strobe();
    test_back_to_back();
    test_shadow();
    test_reset_abort();
    test_cont();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
